stack_pointer_unit: RTL and testbench
=====================================

// Module: stack_pointer_unit
// PURPOSE
//   Parametrised AVR stack-pointer engine: holds SP, executes PUSH/POP/CALL/RET sequences and drives the
//   data-SRAM port. Byte-wise SPH/SPL I/O writes are supported. Sits between the instruction decoder and
//   data memory; PC_BYTES-wide return addresses are moved one byte per cycle.
// PARAMETERS
//   ADDR_W    16      SP / SRAM address width (split into SPH = [ADDR_W-1:8], SPL = [7:0])
//   PC_BYTES  2       bytes per return address pushed/popped by CALL/RET (PC_W = 8*PC_BYTES)
//   RESET_SP  16'h0000 SP value after reset
//   SRAM_LO   16'h0060 lowest legal stack address (used only with SP_BOUNDS_CHECK_EN)
// PORTS
//   clk        in   1        clock, rising edge
//   clr_n      in   1        asynchronous active-low reset
//   io_we_h    in   1        write io_data to SPH
//   io_we_l    in   1        write io_data to SPL
//   io_data    in   8        I/O write data
//   op_push    in   1        push push_data (1 byte)
//   op_pop     in   1        pop 1 byte to pop_data
//   op_call    in   1        push ret_addr_in (PC_BYTES bytes)
//   op_ret     in   1        pop PC_BYTES bytes to ret_addr_out
//   push_data  in   8        byte for op_push
//   ret_addr_in in  PC_W     return address for op_call
//   mem_rdata  in   8        SRAM read data, valid the cycle after mem_re
//   mem_addr   out  ADDR_W   SRAM address
//   mem_we     out  1        SRAM write strobe
//   mem_re     out  1        SRAM read strobe
//   mem_wdata  out  8        SRAM write data
//   pop_data   out  8        popped byte, valid with done
//   ret_addr_out out PC_W    popped return address, valid with done
//   busy       out  1        sequence in progress; op/io strobes ignored
//   done       out  1        one-cycle pulse when an operation completes
//   spH, spL   out  8 each   SP bytes;  sp  out  ADDR_W  full SP
//   sp_ovf, sp_unf out 1 each sticky bounds flags (SP_BOUNDS_CHECK_EN only)
// BEHAVIOUR
//   Reset: SP=RESET_SP; busy, done, mem_we, mem_re, sp_ovf, sp_unf = 0; pop_data, ret_addr_out = 0; state IDLE.
//   Accept only in IDLE. Priority io_we_* > op_ret > op_call > op_pop > op_push; losers are dropped, no done.
//   io_we_h/io_we_l: SP byte updated next edge; both may be asserted together. No done pulse.
//   PUSH (1 cycle): mem_addr=SP, mem_we=1, mem_wdata=push_data; SP<=SP-1; done in same cycle.
//   POP (2 cycles): c0 mem_addr=SP+1, mem_re=1, SP<=SP+1, busy=1; c1 pop_data<=mem_rdata, done=1.
//   CALL (PC_BYTES cycles, state CALL_WR): byte k=0..PC_BYTES-1 = ret_addr_in[8k+:8] (LSB first) written to SP,
//     SP--; ret_addr_in captured at accept. busy is high until the last byte is written; done on the last byte.
//   RET (PC_BYTES+1 cycles, states RET_RD -> RET_LAST): each cycle SP++ with a read at the new SP; the
//     returned byte fills ret_addr_out MSB first; done on the capture of the final byte.
//   Arithmetic is modulo 2^ADDR_W; SP=0 push -> SP=all-ones, wraps silently (no check).
//   FSM: IDLE, CALL_WR, POP_WAIT, RET_RD, RET_LAST; byte counter is $clog2(PC_BYTES+1) bits.
//   clr_n asserted mid-sequence aborts immediately to reset values; partial SRAM writes remain.
// CONFIGURATION
//   SP_BOUNDS_CHECK_EN defined: a push/CALL byte with SP<SRAM_LO sets sp_ovf, mem_we suppressed, SP unchanged;
//     a pop/RET read with SP+1 wrapping to 0 sets sp_unf, read still issued. Flags clear only on reset.
//   Undefined: sp_ovf=sp_unf=0 constant; no suppression, pure modulo behaviour.
// STRUCTURE
//   Package avr_sp_pkg: sp_state_t enum, op priority encoding, default RESET_SP and SRAM_LO constants.
//   Sub-module sp_byte_register: 8-bit register with enable and async clear; two instances for SPH and SPL
//     (SPH has ADDR_W-8 bits used).
// TESTING
//   Reset with SP loaded 0x085F -> sp=0x0000, busy=0, done=0, flags 0.
//   io_we_h=1 with data 0x08, then io_we_l=1 with data 0x5F -> sp=0x085F; push 0xA5 -> [0x085F]=0xA5, sp=0x085E.
//   CALL ret 0x1234 at SP=0x085F -> [0x085F]=0x34, [0x085E]=0x12, sp=0x085D, done after 2 cycles; RET -> 0x1234, sp=0x085F.
//   POP with mem model -> pop_data valid cycle 2 with done; op_push during busy -> ignored, SP unaffected.
//   Simultaneous io_we_l and op_push in IDLE -> SPL written, no memory write, no done.
//   SP=0x005F push with SP_BOUNDS_CHECK_EN -> sp_ovf=1, no mem_we; without it -> write 0x005F, sp=0x005E.

Source files
------------

// File: rtl/avr_sp_pkg.sv
// Shared types and constants for the AVR stack-pointer engine.
//   sp_state_t : sequencing FSM states
//   sp_op_t    : request class after priority resolution
//   decode_op  : resolves simultaneous requests (io > ret > call > pop > push)
package avr_sp_pkg;

  localparam logic [15:0] DefResetSp = 16'h0000;
  localparam logic [15:0] DefSramLo  = 16'h0060;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCallWr  = 3'd1,
    StPopWait = 3'd2,
    StRetRd   = 3'd3,
    StRetLast = 3'd4
  } sp_state_t;

  typedef enum logic [2:0] {
    OpNone = 3'd0,
    OpIo   = 3'd1,
    OpRet  = 3'd2,
    OpCall = 3'd3,
    OpPop  = 3'd4,
    OpPush = 3'd5
  } sp_op_t;

  function automatic sp_op_t decode_op(input logic io_we, input logic ret, input logic call,
                                       input logic pop, input logic push);
    if (io_we)     return OpIo;
    else if (ret)  return OpRet;
    else if (call) return OpCall;
    else if (pop)  return OpPop;
    else if (push) return OpPush;
    else           return OpNone;
  endfunction

endpackage

// File: rtl/sp_byte_register.sv
// One byte lane of the stack pointer: register with load enable and asynchronous clear.
// Ports:
//   clk   : clock, rising edge
//   clr_n : asynchronous active-low clear to ResetVal
//   en    : load d on the next rising edge
//   d     : next value
//   q     : current value
module sp_byte_register #(
  parameter int unsigned      Width    = 8,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= ResetVal;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/stack_pointer_unit.sv
// AVR stack-pointer engine: holds SP, sequences PUSH/POP/CALL/RET and drives the data-SRAM port.
// Return addresses move one byte per cycle; CALL writes LSB first, RET reassembles MSB first.
// Optional build macro SP_BOUNDS_CHECK_EN: stack writes below SRAM_LO are suppressed and flagged
// (sp_ovf); reads whose address wraps to 0 are flagged (sp_unf). Without it both flags are 0.
// Ports:
//   clk, clr_n                 : clock, asynchronous active-low reset
//   io_we_h, io_we_l, io_data  : byte writes to SPH / SPL
//   op_push/op_pop/op_call/op_ret, push_data, ret_addr_in : operation requests (IDLE only)
//   mem_rdata                  : SRAM read data, one cycle after mem_re
//   mem_addr/mem_we/mem_re/mem_wdata : SRAM port
//   pop_data, ret_addr_out     : results, valid with done and held afterwards
//   busy, done                 : sequence in progress / completion pulse
//   spH, spL, sp               : stack pointer views
//   sp_ovf, sp_unf             : sticky bounds flags
module stack_pointer_unit
  import avr_sp_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       PC_BYTES = 2,
  parameter logic [ADDR_W-1:0] RESET_SP = ADDR_W'(DefResetSp),
  parameter logic [ADDR_W-1:0] SRAM_LO  = ADDR_W'(DefSramLo)
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    io_we_h,
  input  logic                    io_we_l,
  input  logic [7:0]              io_data,
  input  logic                    op_push,
  input  logic                    op_pop,
  input  logic                    op_call,
  input  logic                    op_ret,
  input  logic [7:0]              push_data,
  input  logic [8*PC_BYTES-1:0]   ret_addr_in,
  input  logic [7:0]              mem_rdata,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_we,
  output logic                    mem_re,
  output logic [7:0]              mem_wdata,
  output logic [7:0]              pop_data,
  output logic [8*PC_BYTES-1:0]   ret_addr_out,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              spH,
  output logic [7:0]              spL,
  output logic [ADDR_W-1:0]       sp,
  output logic                    sp_ovf,
  output logic                    sp_unf
);

  localparam int unsigned PC_W = 8 * PC_BYTES;
  localparam int unsigned SphW = ADDR_W - 8;
  localparam int unsigned CntW = $clog2(PC_BYTES + 1);

  sp_state_t         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [PC_W-1:0]   call_q, call_d;
  logic [PC_W-1:0]   acc_q, acc_d, acc_next;
  logic [PC_W-1:0]   ret_q, ret_d;
  logic [7:0]        pop_q, pop_d;

  logic [SphW-1:0]   sph_q, sph_din;
  logic [7:0]        spl_q, spl_din;
  logic              sph_en, spl_en;
  logic [ADDR_W-1:0] sp_next, sp_inc, sp_dec;

  logic              io_sel;
  logic              wr_req, rd_req, wr_block;
  logic [7:0]        wr_byte;
  sp_op_t            op;

  assign sp       = {sph_q, spl_q};
  assign spH      = 8'(sph_q);
  assign spL      = spl_q;
  assign sp_inc   = sp + ADDR_W'(1);
  assign sp_dec   = sp - ADDR_W'(1);
  assign cnt_inc  = cnt_q + CntW'(1);
  // Shift in the byte arriving this cycle; the first byte read ends up as the MSB.
  assign acc_next = (acc_q << 8) | PC_W'(mem_rdata);
  assign op       = decode_op(io_we_h | io_we_l, op_ret, op_call, op_pop, op_push);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    call_d       = call_q;
    acc_d        = acc_q;
    ret_d        = ret_q;
    pop_d        = pop_q;
    pop_data     = pop_q;
    ret_addr_out = ret_q;
    busy         = (state_q != StIdle);
    done         = 1'b0;
    io_sel       = 1'b0;
    wr_req       = 1'b0;
    rd_req       = 1'b0;
    wr_byte      = 8'h00;
    mem_addr     = sp;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_wdata    = 8'h00;
    sp_next      = sp;
    sph_en       = 1'b0;
    spl_en       = 1'b0;

    unique case (state_q)
      StIdle: begin
        unique case (op)
          OpIo: begin
            io_sel = 1'b1;
            sph_en = io_we_h;
            spl_en = io_we_l;
          end
          OpRet: begin
            rd_req  = 1'b1;
            busy    = 1'b1;
            cnt_d   = CntW'(1);
            state_d = (PC_BYTES == 1) ? StRetLast : StRetRd;
          end
          OpCall: begin
            wr_req  = 1'b1;
            wr_byte = ret_addr_in[7:0];
            call_d  = ret_addr_in;
            if (PC_BYTES == 1) begin
              done = 1'b1;
            end else begin
              busy    = 1'b1;
              cnt_d   = CntW'(1);
              state_d = StCallWr;
            end
          end
          OpPop: begin
            rd_req  = 1'b1;
            busy    = 1'b1;
            state_d = StPopWait;
          end
          OpPush: begin
            wr_req  = 1'b1;
            wr_byte = push_data;
            done    = 1'b1;
          end
          default: ;
        endcase
      end
      StCallWr: begin
        wr_req  = 1'b1;
        wr_byte = 8'(call_q >> {cnt_q, 3'b000});
        cnt_d   = cnt_inc;
        if (cnt_q == CntW'(PC_BYTES - 1)) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      StPopWait: begin
        pop_d    = mem_rdata;
        pop_data = mem_rdata;
        done     = 1'b1;
        state_d  = StIdle;
      end
      StRetRd: begin
        acc_d  = acc_next;
        rd_req = 1'b1;
        cnt_d  = cnt_inc;
        if (cnt_inc == CntW'(PC_BYTES)) begin
          state_d = StRetLast;
        end
      end
      StRetLast: begin
        ret_d        = acc_next;
        ret_addr_out = acc_next;
        acc_d        = '0;
        cnt_d        = '0;
        done         = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Writes store at SP then post-decrement; reads pre-increment then fetch.
    if (wr_req) begin
      mem_addr  = sp;
      mem_wdata = wr_byte;
      if (!wr_block) begin
        mem_we  = 1'b1;
        sp_next = sp_dec;
        sph_en  = 1'b1;
        spl_en  = 1'b1;
      end
    end
    if (rd_req) begin
      mem_addr = sp_inc;
      mem_re   = 1'b1;
      sp_next  = sp_inc;
      sph_en   = 1'b1;
      spl_en   = 1'b1;
    end

    sph_din = io_sel ? SphW'(io_data) : sp_next[ADDR_W-1:8];
    spl_din = io_sel ? io_data : sp_next[7:0];
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      call_q  <= '0;
      acc_q   <= '0;
      ret_q   <= '0;
      pop_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      call_q  <= call_d;
      acc_q   <= acc_d;
      ret_q   <= ret_d;
      pop_q   <= pop_d;
    end
  end

  sp_byte_register #(
    .Width    (SphW),
    .ResetVal (RESET_SP[ADDR_W-1:8])
  ) u_sph (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (sph_en),
    .d     (sph_din),
    .q     (sph_q)
  );

  sp_byte_register #(
    .Width    (8),
    .ResetVal (RESET_SP[7:0])
  ) u_spl (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (spl_en),
    .d     (spl_din),
    .q     (spl_q)
  );

`ifdef SP_BOUNDS_CHECK_EN
  logic ovf_q, unf_q;

  assign wr_block = (sp < SRAM_LO);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_req && wr_block) ovf_q <= 1'b1;
      // The read is still issued; only the wrap is recorded.
      if (rd_req && (sp_inc == '0)) unf_q <= 1'b1;
    end
  end

  assign sp_ovf = ovf_q;
  assign sp_unf = unf_q;
`else
  logic unused_sram_lo;

  assign wr_block       = 1'b0;
  assign unused_sram_lo = ^SRAM_LO;
  assign sp_ovf         = 1'b0;
  assign sp_unf         = 1'b0;
`endif

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Self-checking bench for stack_pointer_unit (ADDR_W=16, PC_BYTES=2).
// Directed scenarios plus a randomized op stream checked against a byte-queue stack model.
module tb_stack_pointer_unit;

  localparam int AW = 16;
  localparam int PB = 2;
  localparam int PW = 8 * PB;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic          io_we_h = 1'b0, io_we_l = 1'b0;
  logic [7:0]    io_data = 8'h00;
  logic          op_push = 1'b0, op_pop = 1'b0, op_call = 1'b0, op_ret = 1'b0;
  logic [7:0]    push_data = 8'h00;
  logic [PW-1:0] ret_addr_in = '0;
  logic [7:0]    mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_re;
  logic [7:0]    mem_wdata, pop_data;
  logic [PW-1:0] ret_addr_out;
  logic          busy, done;
  logic [7:0]    spH, spL;
  logic [AW-1:0] sp;
  logic          sp_ovf, sp_unf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sram [0:65535];

  always #5 clk = ~clk;

  stack_pointer_unit #(
    .ADDR_W   (AW),
    .PC_BYTES (PB),
    .RESET_SP (16'h0000),
    .SRAM_LO  (16'h0060)
  ) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .io_we_h      (io_we_h),
    .io_we_l      (io_we_l),
    .io_data      (io_data),
    .op_push      (op_push),
    .op_pop       (op_pop),
    .op_call      (op_call),
    .op_ret       (op_ret),
    .push_data    (push_data),
    .ret_addr_in  (ret_addr_in),
    .mem_rdata    (mem_rdata),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_wdata    (mem_wdata),
    .pop_data     (pop_data),
    .ret_addr_out (ret_addr_out),
    .busy         (busy),
    .done         (done),
    .spH          (spH),
    .spL          (spL),
    .sp           (sp),
    .sp_ovf       (sp_ovf),
    .sp_unf       (sp_unf)
  );

  // Synchronous SRAM: write on the strobe edge, read data one cycle later.
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= sram[mem_addr];
  end

  task automatic io_write(input logic h, input logic l, input logic [7:0] d);
    @(negedge clk);
    io_we_h = h; io_we_l = l; io_data = d;
    @(negedge clk);
    io_we_h = 1'b0; io_we_l = 1'b0;
  endtask

  task automatic set_sp(input logic [15:0] v);
    io_write(1'b1, 1'b0, v[15:8]);
    io_write(1'b0, 1'b1, v[7:0]);
  endtask

  task automatic clear_ops();
    op_push = 1'b0; op_pop = 1'b0; op_call = 1'b0; op_ret = 1'b0;
  endtask

  // kind: 0 push, 1 pop, 2 call, 3 ret. cycles = cycle index of done (1 = accept cycle), 0 = none.
  task automatic run_op(input int kind, input logic [7:0] d, input logic [PW-1:0] ra,
                        output int cycles, output logic [7:0] pd, output logic [PW-1:0] rout,
                        output logic we0, output logic [15:0] addr0, output logic [7:0] wd0);
    cycles = 0; pd = '0; rout = '0;
    @(negedge clk);
    push_data = d; ret_addr_in = ra;
    op_push = (kind == 0); op_pop = (kind == 1); op_call = (kind == 2); op_ret = (kind == 3);
    #1;
    we0 = mem_we; addr0 = mem_addr; wd0 = mem_wdata;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) begin
        @(negedge clk);
        clear_ops();
        #1;
      end
      if (done) begin
        cycles = c; pd = pop_data; rout = ret_addr_out;
        break;
      end
    end
    @(negedge clk);
    clear_ops();
    #1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    #2;
    n_tests++; if (sp !== 16'h0000) begin n_fail++; $display("FAIL reset_sp: got %h want 0000", sp); end
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    n_tests++; if (sp_ovf !== 1'b0 || sp_unf !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b%b want 00", sp_ovf, sp_unf); end
    n_tests++; if (pop_data !== 8'h00 || ret_addr_out !== 16'h0000) begin
      n_fail++; $display("FAIL reset_outputs: got %h %h want 00 0000", pop_data, ret_addr_out); end
    @(negedge clk);
    clr_n = 1'b1;
    set_sp(16'h085F);
    n_tests++; if (sp !== 16'h085F) begin n_fail++; $display("FAIL preload_sp: got %h want 085F", sp); end
    #2 clr_n = 1'b0;
    #1;
    n_tests++; if (sp !== 16'h0000) begin n_fail++; $display("FAIL async_reset_sp: got %h want 0000", sp); end
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_io();
    io_write(1'b1, 1'b0, 8'h08);
    n_tests++; if (sp !== 16'h0800) begin n_fail++; $display("FAIL io_sph: got %h want 0800", sp); end
    io_write(1'b0, 1'b1, 8'h5F);
    n_tests++; if (sp !== 16'h085F || spH !== 8'h08 || spL !== 8'h5F) begin
      n_fail++; $display("FAIL io_spl: got %h %h %h want 085F 08 5F", sp, spH, spL); end
    io_write(1'b1, 1'b1, 8'h3C);
    n_tests++; if (sp !== 16'h3C3C) begin n_fail++; $display("FAIL io_both: got %h want 3C3C", sp); end
  endtask

  task automatic test_push();
    int cyc; logic [7:0] pd, wd0; logic [15:0] ro, a0; logic we0;
    set_sp(16'h085F);
    run_op(0, 8'hA5, '0, cyc, pd, ro, we0, a0, wd0);
    n_tests++; if (we0 !== 1'b1 || a0 !== 16'h085F || wd0 !== 8'hA5) begin
      n_fail++; $display("FAIL push_port: got we=%b a=%h d=%h want 1 085F A5", we0, a0, wd0); end
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL push_done: got %0d want 1", cyc); end
    n_tests++; if (sp !== 16'h085E) begin n_fail++; $display("FAIL push_sp: got %h want 085E", sp); end
    n_tests++; if (sram[16'h085F] !== 8'hA5) begin
      n_fail++; $display("FAIL push_mem: got %h want A5", sram[16'h085F]); end
  endtask

  task automatic test_call_ret();
    int cyc; logic [7:0] pd, wd0; logic [15:0] ro, a0; logic we0;
    set_sp(16'h085F);
    run_op(2, 8'h00, 16'h1234, cyc, pd, ro, we0, a0, wd0);
    n_tests++; if (cyc !== PB) begin n_fail++; $display("FAIL call_done: got %0d want %0d", cyc, PB); end
    n_tests++; if (sram[16'h085F] !== 8'h34 || sram[16'h085E] !== 8'h12) begin
      n_fail++; $display("FAIL call_mem: got %h %h want 34 12", sram[16'h085F], sram[16'h085E]); end
    n_tests++; if (sp !== 16'h085D) begin n_fail++; $display("FAIL call_sp: got %h want 085D", sp); end
    run_op(3, 8'h00, '0, cyc, pd, ro, we0, a0, wd0);
    n_tests++; if (cyc !== PB + 1) begin
      n_fail++; $display("FAIL ret_done: got %0d want %0d", cyc, PB + 1); end
    n_tests++; if (ro !== 16'h1234) begin n_fail++; $display("FAIL ret_addr: got %h want 1234", ro); end
    n_tests++; if (sp !== 16'h085F) begin n_fail++; $display("FAIL ret_sp: got %h want 085F", sp); end
  endtask

  task automatic test_pop_busy();
    int cyc; logic [7:0] pd, wd0; logic [15:0] ro, a0; logic we0;
    set_sp(16'h0900);
    run_op(0, 8'h5A, '0, cyc, pd, ro, we0, a0, wd0);
    @(negedge clk);
    op_pop = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b1 || mem_re !== 1'b1 || mem_addr !== 16'h0900 || done !== 1'b0) begin
      n_fail++; $display("FAIL pop_c0: got busy=%b re=%b a=%h done=%b want 1 1 0900 0",
                         busy, mem_re, mem_addr, done); end
    @(negedge clk);
    op_pop = 1'b0; op_push = 1'b1; push_data = 8'h77;
    #1;
    n_tests++; if (done !== 1'b1 || pop_data !== 8'h5A) begin
      n_fail++; $display("FAIL pop_c1: got done=%b data=%h want 1 5A", done, pop_data); end
    n_tests++; if (mem_we !== 1'b0) begin
      n_fail++; $display("FAIL busy_push_we: got %b want 0", mem_we); end
    @(negedge clk);
    op_push = 1'b0;
    #1;
    n_tests++; if (sp !== 16'h0900 || pop_data !== 8'h5A || busy !== 1'b0) begin
      n_fail++; $display("FAIL pop_after: got sp=%h data=%h busy=%b want 0900 5A 0", sp, pop_data, busy); end
  endtask

  task automatic test_priority();
    logic [7:0] pre;
    set_sp(16'h085F);
    pre = sram[16'h085F];
    @(negedge clk);
    io_we_l = 1'b1; io_data = 8'h40; op_push = 1'b1; push_data = 8'hEE;
    #1;
    n_tests++; if (mem_we !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL prio_strobes: got we=%b done=%b want 0 0", mem_we, done); end
    @(negedge clk);
    io_we_l = 1'b0; op_push = 1'b0;
    #1;
    n_tests++; if (sp !== 16'h0840) begin n_fail++; $display("FAIL prio_sp: got %h want 0840", sp); end
    n_tests++; if (sram[16'h085F] !== pre) begin
      n_fail++; $display("FAIL prio_mem: got %h want %h", sram[16'h085F], pre); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [15:0] base;
    int cyc, kind, exp_cyc;
    logic [7:0] pd, wd0, d, exp_b;
    logic [15:0] ro, a0, ra, exp_ra, exp_sp;
    logic we0;
    base = 16'($urandom_range(16'h0400, 16'h0BFF));
    set_sp(base);
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 31) == 0) begin
        base = 16'($urandom_range(16'h0400, 16'h0BFF));
        set_sp(base);
        q.delete();
      end
      kind = $urandom_range(0, 3);
      if (kind == 1 && q.size() < 1) kind = 0;
      if (kind == 3 && q.size() < PB) kind = 2;
      if (q.size() > 300 && (kind == 0 || kind == 2)) kind = kind + 1;
      d  = 8'($urandom);
      ra = 16'($urandom);
      run_op(kind, d, ra, cyc, pd, ro, we0, a0, wd0);
      exp_cyc = 0; exp_b = 8'h00; exp_ra = '0;
      case (kind)
        0: begin q.push_back(d); exp_cyc = 1; end
        1: begin exp_b = q.pop_back(); exp_cyc = 2; end
        2: begin
          for (int k = 0; k < PB; k++) q.push_back(ra[8*k +: 8]);
          exp_cyc = PB;
        end
        default: begin
          for (int k = 0; k < PB; k++) exp_ra = (exp_ra << 8) | 16'(q.pop_back());
          exp_cyc = PB + 1;
        end
      endcase
      exp_sp = 16'(base - 16'(q.size()));
      n_tests++; if (cyc !== exp_cyc) begin
        n_fail++; $display("FAIL rnd_cycles op=%0d it=%0d: got %0d want %0d", kind, it, cyc, exp_cyc); end
      if (kind == 1) begin
        n_tests++; if (pd !== exp_b) begin
          n_fail++; $display("FAIL rnd_pop it=%0d: got %h want %h", it, pd, exp_b); end
      end
      if (kind == 3) begin
        n_tests++; if (ro !== exp_ra) begin
          n_fail++; $display("FAIL rnd_ret it=%0d: got %h want %h", it, ro, exp_ra); end
      end
      n_tests++; if (sp !== exp_sp) begin
        n_fail++; $display("FAIL rnd_sp op=%0d it=%0d: got %h want %h", kind, it, sp, exp_sp); end
    end
  endtask

  task automatic test_bounds();
    int cyc; logic [7:0] pd, wd0; logic [15:0] ro, a0; logic we0;
    set_sp(16'h005F);
    run_op(0, 8'h11, '0, cyc, pd, ro, we0, a0, wd0);
`ifdef SP_BOUNDS_CHECK_EN
    n_tests++; if (we0 !== 1'b0 || sp !== 16'h005F || sp_ovf !== 1'b1) begin
      n_fail++; $display("FAIL bounds_push: got we=%b sp=%h ovf=%b want 0 005F 1", we0, sp, sp_ovf); end
`else
    n_tests++; if (we0 !== 1'b1 || a0 !== 16'h005F || sp !== 16'h005E || sp_ovf !== 1'b0) begin
      n_fail++; $display("FAIL low_push: got we=%b a=%h sp=%h ovf=%b want 1 005F 005E 0",
                         we0, a0, sp, sp_ovf); end
    set_sp(16'h0000);
    run_op(0, 8'h22, '0, cyc, pd, ro, we0, a0, wd0);
    n_tests++; if (sp !== 16'hFFFF || we0 !== 1'b1) begin
      n_fail++; $display("FAIL wrap_push: got sp=%h we=%b want FFFF 1", sp, we0); end
`endif
    set_sp(16'hFFFF);
    run_op(1, 8'h00, '0, cyc, pd, ro, we0, a0, wd0);
    n_tests++; if (cyc !== 2 || sp !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_pop: got cyc=%0d sp=%h want 2 0000", cyc, sp); end
`ifdef SP_BOUNDS_CHECK_EN
    n_tests++; if (sp_unf !== 1'b1) begin n_fail++; $display("FAIL unf_flag: got %b want 1", sp_unf); end
`else
    n_tests++; if (sp_unf !== 1'b0) begin n_fail++; $display("FAIL unf_flag: got %b want 0", sp_unf); end
`endif
  endtask

  initial begin
    test_reset();
    test_io();
    test_push();
    test_call_ret();
    test_pop_busy();
    test_priority();
    test_random();
    test_bounds();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
